// File: rtl/dds_phase_accum.sv
// Phase accumulator with byte-programmed FTW / phase-offset shadows, atomic commit and
// registered truncated phase output. Define DDS_DITHER_EN to add LFSR dither before truncation.
module dds_phase_accum #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 14
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_sync,
  input  logic               i_wr_valid,
  input  logic [2:0]         i_wr_addr,
  input  logic [7:0]         i_wr_data,
  output logic               o_wr_ready,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_phase_valid
);

  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   r_ftw;
  logic [ACC_W-1:0]   r_ftw_sh;
  logic [PHASE_W-1:0] r_poff;
  logic [PHASE_W-1:0] r_poff_sh;
  logic               r_pending;

  logic               w_wr_acc;
  logic               w_apply;
  logic [31:0]        w_ftw_ext;
  logic [15:0]        w_poff_ext;
  logic [ACC_W-1:0]   w_acc_d;
  logic [PHASE_W-1:0] w_phase_nxt;

  assign w_wr_acc   = i_wr_valid && o_wr_ready;
  assign w_apply    = r_pending && i_en;
  assign w_ftw_ext  = 32'(r_ftw_sh);
  assign w_poff_ext = 16'(r_poff_sh);

  // Byte lanes are merged into a widened copy so the unwritten lanes are preserved.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ftw_sh  <= '0;
      r_poff_sh <= '0;
    end else if (w_wr_acc) begin
      case (i_wr_addr)
        3'd0:    r_ftw_sh  <= ACC_W'({w_ftw_ext[31:8], i_wr_data});
        3'd1:    r_ftw_sh  <= ACC_W'({w_ftw_ext[31:16], i_wr_data, w_ftw_ext[7:0]});
        3'd2:    r_ftw_sh  <= ACC_W'({w_ftw_ext[31:24], i_wr_data, w_ftw_ext[15:0]});
        3'd3:    r_poff_sh <= PHASE_W'({w_poff_ext[15:8], i_wr_data});
        3'd4:    r_poff_sh <= PHASE_W'({i_wr_data, w_poff_ext[7:0]});
        default: ;
      endcase
    end
  end

  // wr_ready trails pending by one cycle, so it recovers the cycle after the commit lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending  <= 1'b0;
      o_wr_ready <= 1'b1;
      r_ftw      <= '0;
      r_poff     <= '0;
    end else begin
      if (w_apply) begin
        r_ftw  <= r_ftw_sh;
        r_poff <= r_poff_sh;
      end
      r_pending  <= (w_wr_acc && (i_wr_addr == 3'd5)) || (r_pending && !i_en);
      o_wr_ready <= !r_pending;
    end
  end

`ifdef DDS_DITHER_EN
  // Dither width ACC_W-PHASE_W must lie in 1..16.
  localparam int DITH_W = ACC_W - PHASE_W;
  logic [15:0] r_lfsr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 16'hACE1;
    end else if (i_en) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end

  assign w_acc_d = r_acc + ACC_W'(r_lfsr[DITH_W-1:0]);
`else
  assign w_acc_d = r_acc;
`endif

  assign w_phase_nxt = w_acc_d[ACC_W-1 -: PHASE_W] + r_poff;

  // Phase is built from the pre-update accumulator, so sync still emits the pre-clear value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc         <= '0;
      o_phase       <= '0;
      o_phase_valid <= 1'b0;
    end else begin
      if (i_sync) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= r_acc + r_ftw;
      end
      if (i_en) begin
        o_phase <= w_phase_nxt;
      end
      o_phase_valid <= i_en;
    end
  end

endmodule
